fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 128 ++++++++++++
 tb/tb_fetch_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding imem request, decode hand-off, redirect/flush.
// Optional macro BRANCH_PREDICT_EN steers next_pc from the branch predictor.
module fetch_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pred_instr_o,
   output logic [31:0] pred_pc_o,
   input  logic        pred_branch_i,
   input  logic [31:0] pred_target_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_OUT   = 2'd2,
      S_FLUSH = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   pc_out_q, pc_out_d;
   logic              valid_q, valid_d;
   logic              req_q, req_d;
   logic [XLEN-1:0]   next_pc;

   // Successor of the fetch currently completing
`ifdef BRANCH_PREDICT_EN
   assign next_pc      = pred_branch_i ? pred_target_i : pc_q + XLEN'(4);
   assign pred_instr_o = imem_rdata_i;
   assign pred_pc_o    = pc_q;
`else
   logic pred_unused;
   assign pred_unused  = ^{pred_branch_i, pred_target_i};
   assign next_pc      = pc_q + XLEN'(4);
   assign pred_instr_o = '0;
   assign pred_pc_o    = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_VECTOR;
         instr_q  <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
         req_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         req_q    <= req_d;
      end
   end

   // Next-state: redirect always wins over predictor and sequential PC
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      case (state_q)
         S_REQ: begin
            if (redirect_i) begin
               pc_d = redirect_pc_i;
               // a grant here belongs to the old address; its response must be dropped
               if (imem_gnt_i) state_d = S_FLUSH;
            end else if (imem_gnt_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               state_d = imem_rvalid_i ? S_REQ : S_FLUSH;
            end else if (imem_rvalid_i) begin
               instr_d  = imem_rdata_i;
               pc_out_d = pc_q;
               pc_d     = next_pc;
               valid_d  = 1'b1;
               state_d  = S_OUT;
            end
         end
         S_OUT: begin
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               valid_d = 1'b0;
               state_d = S_REQ;
            end else if (ready_i) begin
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end
         S_FLUSH: begin
            if (redirect_i) pc_d = redirect_pc_i;
            // the stale response is consumed even if a redirect lands with it
            if (imem_rvalid_i) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
      req_d = (state_d == S_REQ);
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = pc_q;
   assign instr_o     = instr_q;
   assign pc_o        = pc_out_q;
   assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: randomized memory/decode/redirect traffic
// checked against a stream-level reference (delivered PCs run sequentially from the last redirect).
`timescale 1ns/1ps
module tb_fetch_controller;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pred_instr_o;
   logic [31:0] pred_pc_o;
   logic        pred_branch_i;
   logic [31:0] pred_target_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic        ready_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   fetch_controller #(.RESET_VECTOR(RV)) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .pred_instr_o (pred_instr_o),
      .pred_pc_o    (pred_pc_o),
      .pred_branch_i(pred_branch_i),
      .pred_target_i(pred_target_i),
      .instr_o      (instr_o),
      .pc_o         (pc_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus knobs
   int gnt_pct, dmin, dmax, ready_pct, redir_pct, spur_pct;
   bit force_redir;
   logic [31:0] force_pc;
   bit chk_stream;

   // memory and reference state
   bit          outstanding;
   logic [31:0] out_addr;
   int          dly;
   logic [31:0] exp_next;
   int          cyc;
   int          last_xfer_cyc;
   int          xcyc[$];
   logic [31:0] xpc[$];

   // previous-cycle observations
   bit          p_req, p_gnt, p_redir, p_valid, p_ready;
   logic [31:0] p_addr, p_rpc, p_pc, p_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   function automatic bit pct(input int p);
      return int'($urandom_range(99, 0)) < p;
   endfunction

   task automatic do_reset();
      rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      pred_branch_i = 1'b0; pred_target_i = '0; ready_i = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = '0;
      @(negedge clk); @(negedge clk);
      rst_i = 1'b0;
      outstanding = 0; dly = 0; exp_next = RV; force_redir = 0;
      p_req = 0; p_valid = 0; p_gnt = 0; p_redir = 0; p_ready = 0;
      last_xfer_cyc = cyc;
   endtask

   // One clock: sample at negedge, check, drive inputs, update model, advance
   task automatic cycle();
      logic rq, vl, gn, rv, rd, rdy;
      logic [31:0] ad, po, io, rnd, rpc;
      rq = imem_req_o; ad = imem_addr_o; vl = valid_o; po = pc_o; io = instr_o;

      if (p_req && !p_gnt) begin
         n_checks++;
         if (rq !== 1'b1 || ad !== (p_redir ? p_rpc : p_addr)) begin
            n_fail++;
            $display("FAIL req_hold cyc=%0d req=%b addr=%h required req=1 addr=%h", cyc, rq, ad, p_redir ? p_rpc : p_addr);
         end
      end
      if (p_valid && !p_ready && !p_redir) begin
         n_checks++;
         if (vl !== 1'b1 || po !== p_pc || io !== p_instr) begin
            n_fail++;
            $display("FAIL out_hold cyc=%0d valid=%b pc=%h instr=%h required 1 %h %h", cyc, vl, po, io, p_pc, p_instr);
         end
      end
      n_checks++;
      if ((rq && vl) || (rq && ad[1:0] !== 2'b00)) begin
         n_fail++;
         $display("FAIL req_valid_excl cyc=%0d req=%b valid=%b addr=%h required exclusive and aligned", cyc, rq, vl, ad);
      end

      rv = 1'b0;
      if (outstanding && dly == 0) rv = 1'b1;
      else if (!outstanding && pct(spur_pct)) rv = 1'b1;
      gn  = rq && pct(gnt_pct);
      rdy = pct(ready_pct);
      rd  = force_redir || pct(redir_pct);
      rnd = $urandom();
      rpc = force_redir ? force_pc : {rnd[31:2], 2'b00};
      force_redir = 0;
      imem_gnt_i = gn; imem_rvalid_i = rv; ready_i = rdy;
      redirect_i = rd; redirect_pc_i = rpc;
      imem_rdata_i = (rv && outstanding) ? mem_word(out_addr) : $urandom();
      #1;
      n_checks++;
`ifdef BRANCH_PREDICT_EN
      if (pred_instr_o !== imem_rdata_i) begin
         n_fail++;
         $display("FAIL pred_instr cyc=%0d got=%h required=%h", cyc, pred_instr_o, imem_rdata_i);
      end
`else
      if (pred_instr_o !== 32'h0 || pred_pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL pred_zero cyc=%0d instr=%h pc=%h required 0 0", cyc, pred_instr_o, pred_pc_o);
      end
`endif

      if (gn) begin
         n_checks++;
         if (outstanding) begin
            n_fail++;
            $display("FAIL one_outstanding cyc=%0d got=2 required<=1", cyc);
         end
      end
      if (rv && outstanding) outstanding = 0;
      else if (outstanding) dly--;
      if (gn) begin
         outstanding = 1; out_addr = ad; dly = $urandom_range(dmax, dmin);
      end

      if (rd) begin
         exp_next = rpc;
      end else if (vl && rdy) begin
         xcyc.push_back(cyc); xpc.push_back(po); last_xfer_cyc = cyc;
         if (chk_stream) begin
            n_checks++;
            if (po !== exp_next || io !== mem_word(po)) begin
               n_fail++;
               $display("FAIL stream cyc=%0d pc=%h instr=%h required pc=%h instr=%h", cyc, po, io, exp_next, mem_word(exp_next));
            end
         end
         exp_next = po + 32'd4;
      end

      p_req = rq; p_gnt = gn; p_redir = rd; p_addr = ad; p_rpc = rpc;
      p_valid = vl; p_ready = rdy; p_pc = po; p_instr = io;
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_knobs(input int g, input int d0, input int d1, input int r, input int re, input int sp);
      gnt_pct = g; dmin = d0; dmax = d1; ready_pct = r; redir_pct = re; spur_pct = sp;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== RV || valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset req=%b addr=%h valid=%b instr=%h pc=%h required 1 %h 0 0 0", imem_req_o, imem_addr_o, valid_o, instr_o, pc_o, RV);
      end
   endtask

   task automatic test_sequential();
      do_reset(); chk_stream = 1;
      set_knobs(100, 0, 0, 100, 0, 0);
      xcyc.delete(); xpc.delete();
      for (int i = 0; i < 9; i++) cycle();
      n_checks++;
      if (xpc.size() != 3) begin
         n_fail++;
         $display("FAIL seq_count got=%0d required=3", xpc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (xpc[i] !== RV + 32'(4 * i)) begin
               n_fail++;
               $display("FAIL seq_pc idx=%0d got=%h required=%h", i, xpc[i], RV + 32'(4 * i));
            end
         end
         n_checks++;
         if (xcyc[1] - xcyc[0] != 3 || xcyc[2] - xcyc[1] != 3) begin
            n_fail++;
            $display("FAIL seq_interval got=%0d,%0d required=3,3", xcyc[1] - xcyc[0], xcyc[2] - xcyc[1]);
         end
      end
   endtask

   task automatic test_predict();
      logic [31:0] want;
`ifdef BRANCH_PREDICT_EN
      want = 32'h0000_01F0;
`else
      want = 32'h0000_0204;
`endif
      do_reset(); chk_stream = 0;
      set_knobs(0, 0, 0, 0, 0, 0);
      force_redir = 1; force_pc = 32'h200;
      cycle();
      pred_branch_i = 1'b1; pred_target_i = 32'h1F0;
      set_knobs(100, 0, 0, 0, 0, 0);
      cycle(); cycle();
      n_checks++;
      if (valid_o !== 1'b1 || pc_o !== 32'h200 || imem_addr_o !== want) begin
         n_fail++;
         $display("FAIL predict valid=%b pc=%h next_addr=%h required 1 200 %h", valid_o, pc_o, imem_addr_o, want);
      end
      set_knobs(0, 0, 0, 100, 0, 0);
      cycle();
      n_checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== want) begin
         n_fail++;
         $display("FAIL predict_req req=%b addr=%h required 1 %h", imem_req_o, imem_addr_o, want);
      end
      pred_branch_i = 1'b0; pred_target_i = '0;
   endtask

   task automatic test_redirect_wait();
      int n;
      do_reset(); chk_stream = 1;
      set_knobs(100, 2, 2, 100, 0, 0);
      cycle();
      force_redir = 1; force_pc = 32'h400;
      cycle();
      n_checks++;
      if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_enter req=%b valid=%b required 0 0", imem_req_o, valid_o);
      end
      cycle(); cycle();
      n_checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_exit req=%b addr=%h valid=%b required 1 400 0", imem_req_o, imem_addr_o, valid_o);
      end
      n = 0;
      while (valid_o !== 1'b1 && n < 20) begin cycle(); n++; end
      n_checks++;
      if (valid_o !== 1'b1 || pc_o !== 32'h400 || instr_o !== mem_word(32'h400)) begin
         n_fail++;
         $display("FAIL redirect_first valid=%b pc=%h instr=%h required 1 400 %h", valid_o, pc_o, instr_o, mem_word(32'h400));
      end
   endtask

   task automatic test_stall();
      logic [31:0] hp, hi;
      do_reset(); chk_stream = 1;
      set_knobs(100, 0, 0, 0, 0, 0);
      cycle(); cycle();
      hp = pc_o; hi = instr_o;
      n_checks++;
      if (valid_o !== 1'b1 || hp !== RV) begin
         n_fail++;
         $display("FAIL stall_start valid=%b pc=%h required 1 %h", valid_o, hp, RV);
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (valid_o !== 1'b1 || pc_o !== hp || instr_o !== hi || imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall cyc=%0d valid=%b pc=%h req=%b required 1 %h 0", i, valid_o, pc_o, imem_req_o, hp);
         end
         cycle();
      end
      set_knobs(0, 0, 0, 100, 0, 0);
      cycle();
      n_checks++;
      if (imem_req_o !== 1'b1 || valid_o !== 1'b0 || imem_addr_o !== RV + 32'd4) begin
         n_fail++;
         $display("FAIL stall_release req=%b valid=%b addr=%h required 1 0 %h", imem_req_o, valid_o, imem_addr_o, RV + 32'd4);
      end
   endtask

   task automatic test_gnt_hold_wrap();
      do_reset(); chk_stream = 1;
      set_knobs(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (imem_req_o !== 1'b1 || imem_addr_o !== RV) begin
            n_fail++;
            $display("FAIL gnt_hold cyc=%0d req=%b addr=%h required 1 %h", i, imem_req_o, imem_addr_o, RV);
         end
         cycle();
      end
      force_redir = 1; force_pc = 32'hFFFF_FFFC;
      cycle();
      set_knobs(100, 0, 0, 0, 0, 0);
      cycle(); cycle();
      n_checks++;
      if (pc_o !== 32'hFFFF_FFFC || imem_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap pc=%h next_addr=%h required fffffffc 00000000", pc_o, imem_addr_o);
      end
      set_knobs(0, 0, 0, 100, 0, 0);
      cycle();
      n_checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_req req=%b addr=%h required 1 0", imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_random();
      do_reset(); chk_stream = 1;
      for (int blk = 0; blk < 15; blk++) begin
         set_knobs($urandom_range(100, 30), 0, $urandom_range(3, 0), $urandom_range(100, 30),
                   $urandom_range(5, 0), $urandom_range(15, 0));
         for (int i = 0; i < 200; i++) begin
            cycle();
            if (cyc - last_xfer_cyc > 300) begin
               n_checks++; n_fail++;
               $display("FAIL liveness no transfer for %0d cycles required <=300", cyc - last_xfer_cyc);
               last_xfer_cyc = cyc;
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      int n;
      set_knobs(100, 3, 3, 100, 0, 0);
      n = 0;
      while (!outstanding && n < 20) begin cycle(); n++; end
      n_checks++;
      if (!outstanding) begin
         n_fail++;
         $display("FAIL midflight_setup outstanding=0 required 1");
      end
      test_reset();
      set_knobs(80, 0, 2, 80, 2, 10);
      for (int i = 0; i < 100; i++) cycle();
   endtask

   initial begin
      cyc = 0; chk_stream = 1; force_pc = '0;
      set_knobs(0, 0, 0, 0, 0, 0);
      test_reset();
      test_sequential();
      test_predict();
      test_redirect_wait();
      test_stall();
      test_gnt_hold_wrap();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation did not finish within 2ms");
      $fatal(1, "timeout");
   end

endmodule
